// File: rtl/alu_multicycle_if.sv
// Handshake and operand/result bundle for alu_multicycle.
// The master side (issue stage plus writeback) drives operands, in_valid and out_ready.
// The slave side (the ALU) drives in_ready, the registered result and status.
interface alu_multicycle_if #(
  parameter int WIDTH  = 32,
  parameter int CTRL_W = 4
);
  logic              in_valid;
  logic              in_ready;
  logic [WIDTH-1:0]  SrcA;
  logic [WIDTH-1:0]  SrcB;
  logic [CTRL_W-1:0] ALUControl;
  logic              out_valid;
  logic              out_ready;
  logic [WIDTH-1:0]  ALUResult;
  logic              Zero;
  logic              busy;

  modport master (
    output in_valid, SrcA, SrcB, ALUControl, out_ready,
    input  in_ready, out_valid, ALUResult, Zero, busy
  );

  modport slave (
    input  in_valid, SrcA, SrcB, ALUControl, out_ready,
    output in_ready, out_valid, ALUResult, Zero, busy
  );
endinterface

// File: rtl/alu_multicycle.sv
// Multi-cycle ALU with registered result and valid/ready handshakes on both sides.
// Single-cycle operations complete one cycle after accept. MULLO/DIVU/REMU run as
// radix-2 iterative operations taking WIDTH+1 cycles, but only when the macro
// ALU_MULDIV_EN is defined. Without it those opcodes behave like unsupported ones
// (single-cycle, result 0) and no multiplier/divider logic is built.
module alu_multicycle #(
  parameter int WIDTH  = 32,
  parameter int CTRL_W = 4
) (
  input logic             clk,
  input logic             rst_n,
  alu_multicycle_if.slave bus
);
  localparam int SH_W = $clog2(WIDTH);

  localparam logic [3:0] OP_ADD   = 4'b0000;
  localparam logic [3:0] OP_SUB   = 4'b0001;
  localparam logic [3:0] OP_AND   = 4'b0010;
  localparam logic [3:0] OP_OR    = 4'b0011;
  localparam logic [3:0] OP_SLL   = 4'b0100;
  localparam logic [3:0] OP_SLT   = 4'b0101;
  localparam logic [3:0] OP_PASSB = 4'b0110;
  localparam logic [3:0] OP_XOR   = 4'b0111;
  localparam logic [3:0] OP_SRL   = 4'b1000;
  localparam logic [3:0] OP_SRA   = 4'b1001;
  localparam logic [3:0] OP_SLTU  = 4'b1010;
  localparam logic [3:0] OP_MULLO = 4'b1011;
  localparam logic [3:0] OP_DIVU  = 4'b1100;
  localparam logic [3:0] OP_REMU  = 4'b1101;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state;
  state_t           state_next;
  logic             accept;
  logic             upper_zero;
  logic             start_iter;
  logic             iter_done;
  logic [3:0]       op;
  logic [SH_W-1:0]  shamt;
  logic [WIDTH-1:0] single_result;
  logic [WIDTH-1:0] iter_result;
  logic [WIDTH-1:0] result_q;
  logic             zero_q;

  assign op    = bus.ALUControl[3:0];
  assign shamt = bus.SrcB[SH_W-1:0];

  // Opcodes with any control bit above bit 3 set are treated as unsupported.
  if (CTRL_W > 4) begin : g_ctrl_wide
    assign upper_zero = ~|bus.ALUControl[CTRL_W-1:4];
  end else begin : g_ctrl_narrow
    assign upper_zero = 1'b1;
  end

  assign bus.in_ready  = rst_n & ((state == IDLE) | ((state == DONE) & bus.out_ready));
  assign accept        = bus.in_valid & bus.in_ready;
  assign bus.out_valid = (state == DONE);
  assign bus.ALUResult = result_q;
  assign bus.Zero      = zero_q;

  // Single-cycle result from the live operands; unsupported and iterative codes give 0.
  always_comb begin
    single_result = '0;
    if (upper_zero) begin
      case (op)
        OP_ADD:   single_result = bus.SrcA + bus.SrcB;
        OP_SUB:   single_result = bus.SrcA - bus.SrcB;
        OP_AND:   single_result = bus.SrcA & bus.SrcB;
        OP_OR:    single_result = bus.SrcA | bus.SrcB;
        OP_SLL:   single_result = bus.SrcA << shamt;
        OP_SLT:   single_result = {{(WIDTH-1){1'b0}}, ($signed(bus.SrcA) < $signed(bus.SrcB))};
        OP_PASSB: single_result = bus.SrcB;
        OP_XOR:   single_result = bus.SrcA ^ bus.SrcB;
        OP_SRL:   single_result = bus.SrcA >> shamt;
        OP_SRA:   single_result = $signed(bus.SrcA) >>> shamt;
        OP_SLTU:  single_result = {{(WIDTH-1){1'b0}}, (bus.SrcA < bus.SrcB)};
        default:  single_result = '0;
      endcase
    end
  end

`ifdef ALU_MULDIV_EN
  localparam int CNT_W = SH_W + 1;

  // acc holds the product (MULLO) or partial remainder (DIVU/REMU);
  // op_a holds the shifting multiplicand or the dividend turning into the quotient;
  // op_b holds the shifting multiplier or the fixed divisor.
  logic [CNT_W-1:0] count;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             iter_mul;
  logic             iter_rem;
  logic [WIDTH:0]   rem_shift;
  logic             div_ge;

  assign start_iter  = upper_zero & ((op == OP_MULLO) | (op == OP_DIVU) | (op == OP_REMU));
  assign iter_done   = (count == CNT_W'(WIDTH));
  assign rem_shift   = {acc, op_a[WIDTH-1]};
  assign div_ge      = (rem_shift >= {1'b0, op_b});
  assign iter_result = (iter_mul | iter_rem) ? acc : op_a;
  assign bus.busy    = (state == BUSY);

  // Latch operands on accept, then perform one shift-add or restoring-divide step per cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count    <= '0;
      acc      <= '0;
      op_a     <= '0;
      op_b     <= '0;
      iter_mul <= 1'b0;
      iter_rem <= 1'b0;
    end else if (accept && start_iter) begin
      count    <= '0;
      acc      <= '0;
      op_a     <= bus.SrcA;
      op_b     <= bus.SrcB;
      iter_mul <= (op == OP_MULLO);
      iter_rem <= (op == OP_REMU);
    end else if (state == BUSY && !iter_done) begin
      count <= count + CNT_W'(1);
      if (iter_mul) begin
        if (op_b[0]) acc <= acc + op_a;
        op_a <= op_a << 1;
        op_b <= op_b >> 1;
      end else if (div_ge) begin
        acc  <= rem_shift[WIDTH-1:0] - op_b;
        op_a <= {op_a[WIDTH-2:0], 1'b1};
      end else begin
        acc  <= rem_shift[WIDTH-1:0];
        op_a <= {op_a[WIDTH-2:0], 1'b0};
      end
    end
  end
`else
  assign start_iter  = 1'b0;
  assign iter_done   = 1'b0;
  assign iter_result = '0;
  assign bus.busy    = 1'b0;
`endif

  // State register; reset abandons any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state logic: DONE holds until the consumer takes the result, chaining a new accept if present.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (accept) state_next = start_iter ? BUSY : DONE;
      BUSY: if (iter_done) state_next = DONE;
      DONE: begin
        if (bus.out_ready) begin
          if (accept) state_next = start_iter ? BUSY : DONE;
          else        state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Result register: loaded on a single-cycle accept or when an iterative op finishes, else held.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_q <= '0;
      zero_q   <= 1'b0;
    end else if (accept && !start_iter) begin
      result_q <= single_result;
      zero_q   <= (single_result == '0);
    end else if (state == BUSY && iter_done) begin
      result_q <= iter_result;
      zero_q   <= (iter_result == '0);
    end
  end
endmodule

// File: tb/tb_alu_multicycle.sv
// Self-checking bench for alu_multicycle (WIDTH=32). Expected results and latencies
// come from a plain-arithmetic reference model that follows ALU_MULDIV_EN.
module tb_alu_multicycle;
  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  alu_multicycle_if #(.WIDTH(32), .CTRL_W(4)) bus ();

  alu_multicycle #(.WIDTH(32), .CTRL_W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference result for one operation, written from the opcode table.
  function automatic logic [31:0] model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    int          sh;
    logic [31:0] ones;
    sh   = int'(b[4:0]);
    ones = 32'hFFFF_FFFF;
    p    = 64'(a) * 64'(b);
    case (op)
      4'd0:  return a + b;
      4'd1:  return a - b;
      4'd2:  return a & b;
      4'd3:  return a | b;
      4'd4:  return a << sh;
      4'd5:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd6:  return b;
      4'd7:  return a ^ b;
      4'd8:  return a >> sh;
      4'd9:  return (a >> sh) | (a[31] ? ~(ones >> sh) : 32'd0);
      4'd10: return (a < b) ? 32'd1 : 32'd0;
`ifdef ALU_MULDIV_EN
      4'd11: return p[31:0];
      4'd12: return (b == 0) ? ones : a / b;
      4'd13: return (b == 0) ? a : a % b;
`endif
      default: return 32'd0;
    endcase
  endfunction

  // Cycles from accept to out_valid.
  function automatic int model_latency(input logic [3:0] op);
`ifdef ALU_MULDIV_EN
    if (op == 4'd11 || op == 4'd12 || op == 4'd13) return 33;
`endif
    return (op == 4'hF) ? 1 : 1;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one op, wait for its result, check it, then consume it.
  task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_r, input string name);
    int   cyc;
    int   exp_lat;
    logic busy_bad;
    exp_lat = model_latency(op);
    cyc = 0;
    while (bus.in_ready !== 1'b1 && cyc < 100) begin
      step();
      cyc++;
    end
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL %s in_ready_wait: got %b expected 1", name, bus.in_ready);
    end
    bus.in_valid   = 1'b1;
    bus.ALUControl = op;
    bus.SrcA       = a;
    bus.SrcB       = b;
    step();
    bus.in_valid   = 1'b0;
    bus.SrcA       = $urandom;
    bus.SrcB       = $urandom;
    bus.ALUControl = 4'($urandom);
    cyc      = 1;
    busy_bad = 1'b0;
    while (bus.out_valid !== 1'b1 && cyc < 200) begin
      if (bus.in_ready !== 1'b0 || bus.busy !== 1'b1) busy_bad = 1'b1;
      step();
      cyc++;
    end
    if (exp_lat > 1) begin
      checks++;
      if (busy_bad) begin
        errors++;
        $display("[TB] FAIL %s busy_in_ready: got busy/in_ready wrong while iterating expected busy=1 in_ready=0", name);
      end
    end
    checks++;
    if (cyc != exp_lat) begin
      errors++;
      $display("[TB] FAIL %s latency: got %0d expected %0d", name, cyc, exp_lat);
    end
    checks++;
    if (bus.ALUResult !== exp_r) begin
      errors++;
      $display("[TB] FAIL %s result: got %h expected %h", name, bus.ALUResult, exp_r);
    end
    checks++;
    if (bus.Zero !== (exp_r == 32'd0)) begin
      errors++;
      $display("[TB] FAIL %s zero: got %b expected %b", name, bus.Zero, (exp_r == 32'd0));
    end
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL %s busy_done: got %b expected 0", name, bus.busy);
    end
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL %s consumed: got out_valid %b expected 0", name, bus.out_valid);
    end
  endtask

  task automatic test_reset();
    rst_n          = 1'b0;
    bus.in_valid   = 1'b0;
    bus.out_ready  = 1'b0;
    bus.SrcA       = '0;
    bus.SrcB       = '0;
    bus.ALUControl = '0;
    step();
    step();
    rst_n = 1'b1;
    #1;
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL reset_release in_ready: got %b expected 1", bus.in_ready);
    end
    // Leave a nonzero result pending, then reset mid-cycle.
    bus.in_valid   = 1'b1;
    bus.ALUControl = 4'd0;
    bus.SrcA       = 32'd3;
    bus.SrcB       = 32'd4;
    step();
    bus.in_valid = 1'b0;
    checks++;
    if (bus.out_valid !== 1'b1 || bus.ALUResult !== 32'd7) begin
      errors++;
      $display("[TB] FAIL reset_pre_op: got valid %b res %h expected valid 1 res 00000007", bus.out_valid, bus.ALUResult);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.ALUResult !== 32'd0 || bus.Zero !== 1'b0 ||
        bus.in_ready !== 1'b0 || bus.busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_values: got valid %b res %h zero %b in_ready %b busy %b expected 0 0 0 0 0",
               bus.out_valid, bus.ALUResult, bus.Zero, bus.in_ready, bus.busy);
    end
    #2 rst_n = 1'b1;
    step();
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_after: got in_ready %b valid %b expected 1 0", bus.in_ready, bus.out_valid);
    end
  endtask

  task automatic test_back_to_back();
    bus.out_ready  = 1'b1;
    bus.in_valid   = 1'b1;
    bus.ALUControl = 4'd1;
    bus.SrcA       = 32'd5;
    bus.SrcB       = 32'd5;
    step();
    checks++;
    if (bus.out_valid !== 1'b1 || bus.ALUResult !== 32'd0 || bus.Zero !== 1'b1 || bus.in_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL b2b_sub: got valid %b res %h zero %b in_ready %b expected 1 00000000 1 1",
               bus.out_valid, bus.ALUResult, bus.Zero, bus.in_ready);
    end
    bus.ALUControl = 4'd0;
    bus.SrcA       = 32'd3;
    bus.SrcB       = 32'd4;
    step();
    bus.in_valid = 1'b0;
    checks++;
    if (bus.out_valid !== 1'b1 || bus.ALUResult !== 32'd7 || bus.Zero !== 1'b0) begin
      errors++;
      $display("[TB] FAIL b2b_add: got valid %b res %h zero %b expected 1 00000007 0",
               bus.out_valid, bus.ALUResult, bus.Zero);
    end
    step();
    bus.out_ready = 1'b0;
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL b2b_drain: got out_valid %b expected 0", bus.out_valid);
    end
  endtask

  task automatic test_shifts_compare();
    run_op(4'd9,  32'h8000_0000, 32'd4, 32'hF800_0000, "sra");
    run_op(4'd8,  32'h8000_0000, 32'd4, 32'h0800_0000, "srl");
    run_op(4'd5,  32'hFFFF_FFFF, 32'd1, 32'd1,         "slt");
    run_op(4'd10, 32'hFFFF_FFFF, 32'd1, 32'd0,         "sltu");
  endtask

  task automatic test_muldiv();
`ifdef ALU_MULDIV_EN
    run_op(4'd11, 32'h0001_0003, 32'd7, 32'h0007_0015, "mullo");
    run_op(4'd12, 32'd100, 32'd7, 32'd14, "divu");
    run_op(4'd13, 32'd100, 32'd7, 32'd2,  "remu");
    run_op(4'd12, 32'h1234_5678, 32'd0, 32'hFFFF_FFFF, "divu_by0");
    run_op(4'd13, 32'd9, 32'd0, 32'd9, "remu_by0");
`else
    run_op(4'd11, 32'h0001_0003, 32'd7, 32'd0, "mullo_off");
    run_op(4'd12, 32'd100, 32'd7, 32'd0, "divu_off");
    run_op(4'd13, 32'd9, 32'd0, 32'd0, "remu_off");
`endif
    run_op(4'd14, 32'd1, 32'd2, 32'd0, "unsup_e");
    run_op(4'd15, 32'hFFFF_FFFF, 32'd2, 32'd0, "unsup_f");
  endtask

  task automatic test_hold();
    logic [31:0] exp_r;
    int          cyc;
    logic        bad;
    exp_r          = model(4'd12, 32'd100, 32'd7);
    bus.in_valid   = 1'b1;
    bus.ALUControl = 4'd12;
    bus.SrcA       = 32'd100;
    bus.SrcB       = 32'd7;
    step();
    bus.in_valid = 1'b0;
    cyc = 1;
    while (bus.out_valid !== 1'b1 && cyc < 200) begin
      step();
      cyc++;
    end
    bad = 1'b0;
    for (int i = 0; i < 5; i++) begin
      bus.in_valid = 1'b1;
      bus.SrcA     = $urandom;
      if (bus.out_valid !== 1'b1 || bus.ALUResult !== exp_r || bus.in_ready !== 1'b0) bad = 1'b1;
      step();
    end
    bus.in_valid = 1'b0;
    checks++;
    if (bad) begin
      errors++;
      $display("[TB] FAIL hold: got valid %b res %h in_ready %b expected 1 %h 0",
               bus.out_valid, bus.ALUResult, bus.in_ready, exp_r);
    end
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset_mid_op();
    logic seen;
    bus.in_valid   = 1'b1;
    bus.ALUControl = 4'd12;
    bus.SrcA       = 32'd1000;
    bus.SrcB       = 32'd3;
    step();
    bus.in_valid = 1'b0;
    for (int i = 0; i < 9; i++) step();
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0 || bus.in_ready !== 1'b0) begin
      errors++;
      $display("[TB] FAIL midreset_values: got valid %b busy %b in_ready %b expected 0 0 0",
               bus.out_valid, bus.busy, bus.in_ready);
    end
    #2 rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (bus.out_valid !== 1'b0) seen = 1'b1;
    end
    checks++;
    if (seen) begin
      errors++;
      $display("[TB] FAIL midreset_no_result: got out_valid 1 expected 0");
    end
    run_op(4'd0, 32'd1, 32'd1, 32'd2, "add_after_reset");
  endtask

  task automatic test_random();
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    for (int i = 0; i < 80; i++) begin
      op = 4'($urandom_range(0, 15));
      a  = $urandom;
      b  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 20)) : $urandom;
      run_op(op, a, b, model(op, a, b), $sformatf("rand%0d_op%0d", i, op));
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_back_to_back();
    test_shifts_compare();
    test_muldiv();
    test_hold();
    test_reset_mid_op();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
